// File: rtl/id_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_scoreboard_pkg
//  Purpose  : Shared types and helpers for the ID-stage hazard scoreboard:
//             in-flight slot entry, forwarding-select encoding and width
//             helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package id_hazard_scoreboard_pkg;

  // Width of the stored destination index. Kept wide enough for any
  // supported register file; narrower indices are zero-extended on entry.
  localparam int SB_RD_W = 8;

  // Forwarding select value meaning "take the operand from the regfile".
  localparam int FWD_REGFILE = 0;

  // One in-flight destination tracked per pipeline stage after ID.
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wr;
    logic               load;
  } sb_entry_t;

  // Width of a forwarding select: values 0 (regfile) .. num_stages.
  function automatic int fwd_sel_t(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // Width of a slot index, never narrower than one bit.
  function automatic int slot_idx_w(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_scoreboard_if
//  Purpose  : Bundle between the ID-stage decoder (master) and the hazard
//             scoreboard (slave): decoded operands, pipeline control, and the
//             forwarding / stall / issue-ready responses.
//  Revision : 1.0 - initial release
// ============================================================================
interface id_hazard_scoreboard_if
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_IDX_W  = 5,
  parameter int FWD_SEL_W  = fwd_sel_t(NUM_STAGES),
  parameter int CNT_W      = 32
);

  // Decoded instruction presented by ID
  logic                 in_valid;
  logic                 in_ready;
  logic [REG_IDX_W-1:0] rs1_idx;
  logic                 rs1_used;
  logic [REG_IDX_W-1:0] rs2_idx;
  logic                 rs2_used;
  logic [REG_IDX_W-1:0] rd_idx;
  logic                 rd_wr;
  logic                 is_load;

  // Pipeline control
  logic                 advance;
  logic                 flush;

  // Scoreboard responses
  logic [FWD_SEL_W-1:0] fwd_sel_a;
  logic [FWD_SEL_W-1:0] fwd_sel_b;
  logic                 stall;
  logic [CNT_W-1:0]     stall_cycles;

  modport master (
    output in_valid, rs1_idx, rs1_used, rs2_idx, rs2_used,
           rd_idx, rd_wr, is_load, advance, flush,
    input  in_ready, fwd_sel_a, fwd_sel_b, stall, stall_cycles
  );

  modport slave (
    input  in_valid, rs1_idx, rs1_used, rs2_idx, rs2_used,
           rd_idx, rd_wr, is_load, advance, flush,
    output in_ready, fwd_sel_a, fwd_sel_b, stall, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/id_hazard_scoreboard_sb_match.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_scoreboard_sb_match
//  Purpose  : Priority matcher of one source operand against the in-flight
//             slot vector. The youngest (lowest index) matching writer wins.
//  Revision : 1.0 - initial release
// ============================================================================
module id_hazard_scoreboard_sb_match
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_IDX_W  = 5,
  parameter int K_W        = slot_idx_w(NUM_STAGES)
) (
  input  sb_entry_t [NUM_STAGES-1:0] slots_i,
  input  logic [REG_IDX_W-1:0]       src_i,
  input  logic                       used_i,
  output logic                       hit_o,
  output logic [K_W-1:0]             k_o,
  output logic                       is_load_o
);

  logic [SB_RD_W-1:0] w_src_ext;
  logic               w_src_live;

  assign w_src_ext  = SB_RD_W'(src_i);
  // x0 is hardwired and unused sources never create a dependency
  assign w_src_live = used_i & (src_i != '0);

  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    hit_o     = 1'b0;
    k_o       = '0;
    is_load_o = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (w_src_live && slots_i[k].valid && slots_i[k].wr &&
          (slots_i[k].rd == w_src_ext)) begin
        hit_o     = 1'b1;
        k_o       = K_W'(k);
        is_load_o = slots_i[k].load;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_scoreboard
//  Purpose  : ID-stage hazard detection and forwarding for the in-order RV32
//             pipeline. A shift register of in-flight destinations (slot k =
//             stage EX+k) drives per-operand forwarding selects, a load-use
//             stall, the issue handshake and a saturating stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int FLUSH_DEPTH      = 1,
  parameter int REG_IDX_W        = 5,
  parameter int FWD_SEL_W        = fwd_sel_t(NUM_STAGES),
  parameter int CNT_W            = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  id_hazard_scoreboard_if.slave  sb_if
);

  localparam int             K_W          = slot_idx_w(NUM_STAGES);
  // One extra bit so a threshold equal to NUM_STAGES still fits
  localparam logic [K_W:0]   c_LOAD_READY = (K_W+1)'(LOAD_READY_STAGE);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  sb_entry_t [NUM_STAGES-1:0] slots_q;
  sb_entry_t [NUM_STAGES-1:0] slots_d;
  logic [CNT_W-1:0]           stall_cnt_q;
  logic [CNT_W-1:0]           stall_cnt_d;

  logic                 w_hit_a, w_hit_b;
  logic [K_W-1:0]       w_k_a, w_k_b;
  logic                 w_load_a, w_load_b;
  logic                 w_late_a, w_late_b;
  logic                 w_stall;
  logic                 w_ready;
  logic                 w_fire;
  logic [FWD_SEL_W-1:0] w_fwd_a, w_fwd_b;
  sb_entry_t            w_new_entry;

  id_hazard_scoreboard_sb_match #(
    .NUM_STAGES (NUM_STAGES),
    .REG_IDX_W  (REG_IDX_W),
    .K_W        (K_W)
  ) u_match_a (
    .slots_i   (slots_q),
    .src_i     (sb_if.rs1_idx),
    .used_i    (sb_if.rs1_used),
    .hit_o     (w_hit_a),
    .k_o       (w_k_a),
    .is_load_o (w_load_a)
  );

  id_hazard_scoreboard_sb_match #(
    .NUM_STAGES (NUM_STAGES),
    .REG_IDX_W  (REG_IDX_W),
    .K_W        (K_W)
  ) u_match_b (
    .slots_i   (slots_q),
    .src_i     (sb_if.rs2_idx),
    .used_i    (sb_if.rs2_used),
    .hit_o     (w_hit_b),
    .k_o       (w_k_b),
    .is_load_o (w_load_b)
  );

  // Forwarding select: slot k is encoded as k+1, 0 selects the regfile
  assign w_fwd_a = w_hit_a ? (FWD_SEL_W'(w_k_a) + FWD_SEL_W'(1)) : FWD_SEL_W'(FWD_REGFILE);
  assign w_fwd_b = w_hit_b ? (FWD_SEL_W'(w_k_b) + FWD_SEL_W'(1)) : FWD_SEL_W'(FWD_REGFILE);

  // A load whose data is not yet available at the winning slot forces a stall
  assign w_late_a = w_hit_a & w_load_a & ({1'b0, w_k_a} < c_LOAD_READY);
  assign w_late_b = w_hit_b & w_load_b & ({1'b0, w_k_b} < c_LOAD_READY);
  assign w_stall  = sb_if.in_valid & (w_late_a | w_late_b);
  assign w_ready  = sb_if.advance & ~w_stall;
  assign w_fire   = sb_if.in_valid & w_ready;

  assign w_new_entry.valid = 1'b1;
  assign w_new_entry.rd    = SB_RD_W'(sb_if.rd_idx);
  assign w_new_entry.wr    = sb_if.rd_wr;
  assign w_new_entry.load  = sb_if.is_load;

  // Next slot state: shift on advance (issued entry or bubble enters slot 0),
  // then flush kills the youngest slots, including a same-cycle issue
  always_comb begin
    slots_d = slots_q;
    if (sb_if.advance) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[0] = w_fire ? w_new_entry : '0;
    end
    if (sb_if.flush) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (k < FLUSH_DEPTH) begin
          slots_d[k].valid = 1'b0;
        end
      end
    end
  end

  // Stall counter: counts stalled cycles that are not being squashed, holds at max
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && !sb_if.flush && (stall_cnt_q != c_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset wins over flush and advance
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_if.in_ready     = w_ready;
  assign sb_if.fwd_sel_a    = w_fwd_a;
  assign sb_if.fwd_sel_b    = w_fwd_b;
  assign sb_if.stall        = w_stall;
  assign sb_if.stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire
